// File: rtl/sys_reset_pkg.sv
// Shared definitions for the system reset controller: state encoding, reset-cause codes, counter width.
package sys_reset_pkg;

    localparam int CNT_W = 16;

    typedef enum logic [2:0] {
        ST_HOLD      = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_IO_REL    = 3'd2,
        ST_RUN       = 3'd3,
        ST_SOFT      = 3'd4
    } state_t;

    localparam logic [1:0] CAUSE_EXT  = 2'b00;
    localparam logic [1:0] CAUSE_LOCK = 2'b01;
    localparam logic [1:0] CAUSE_SOFT = 2'b10;

    function automatic logic [CNT_W-1:0] load_val(input int p);
        return CNT_W'(p - 1);
    endfunction

endpackage

// File: rtl/sys_reset_ctrl_sync_bit.sv
// Multi-flop synchroniser for a single asynchronous level; clears to 0 on reset.
module sync_bit #(
    parameter int STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) sync_q <= '0;
        else         sync_q <= {sync_q[STAGES-2:0], d_i};
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/sys_reset_ctrl.sv
// Sequences IO then core reset release from a filtered PLL lock flag; handles soft core resets
// and records the cause of the most recent reset.
module sys_reset_ctrl
    import sys_reset_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int LOCK_FILTER = 1024,
    parameter int STAGGER     = 16,
    parameter int SOFT_LEN    = 8
) (
    input  logic       Clock,
    input  logic       Reset_N,
    input  logic       Locked,
    input  logic       Soft_Reset_Req,
    output logic       IO_Reset_N,
    output logic       Core_Reset_N,
    output logic       Ready,
    output logic [1:0] Reset_Cause
);

    if (SYNC_STAGES < 2)                       $error("sys_reset_ctrl: SYNC_STAGES must be >= 2");
    if (LOCK_FILTER < 1 || LOCK_FILTER > 65535) $error("sys_reset_ctrl: LOCK_FILTER out of range");
    if (STAGGER < 1 || STAGGER > 65535)         $error("sys_reset_ctrl: STAGGER out of range");
    if (SOFT_LEN < 1 || SOFT_LEN > 65535)       $error("sys_reset_ctrl: SOFT_LEN out of range");

    localparam logic [CNT_W-1:0] LF_LD = load_val(LOCK_FILTER);
    localparam logic [CNT_W-1:0] ST_LD = load_val(STAGGER);
    localparam logic [CNT_W-1:0] SL_LD = load_val(SOFT_LEN);

    logic lock_s;

    sync_bit #(.STAGES(SYNC_STAGES)) u_lock_sync (
        .clk_i  (Clock),
        .rst_ni (Reset_N),
        .d_i    (Locked),
        .q_o    (lock_s)
    );

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             io_q, io_d, core_q, core_d, rdy_q, rdy_d;
    logic [1:0]       cause_q, cause_d;

    always_ff @(posedge Clock or negedge Reset_N) begin
        if (!Reset_N) begin
            state_q <= ST_HOLD;
            cnt_q   <= '0;
            io_q    <= 1'b0;
            core_q  <= 1'b0;
            rdy_q   <= 1'b0;
            cause_q <= CAUSE_EXT;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            io_q    <= io_d;
            core_q  <= core_d;
            rdy_q   <= rdy_d;
            cause_q <= cause_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        io_d    = io_q;
        core_d  = core_q;
        rdy_d   = rdy_q;
        cause_d = cause_q;
        case (state_q)
            ST_HOLD: begin
                io_d   = 1'b0;
                core_d = 1'b0;
                rdy_d  = 1'b0;
                if (lock_s) begin
                    state_d = ST_WAIT_LOCK;
                    cnt_d   = LF_LD;
                end
            end
            ST_WAIT_LOCK: begin
                // A glitch here restarts the filter but is not a recorded lock loss.
                if (!lock_s)          state_d = ST_HOLD;
                else if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
                else begin
                    state_d = ST_IO_REL;
                    io_d    = 1'b1;
                    cnt_d   = ST_LD;
                end
            end
            ST_IO_REL, ST_RUN, ST_SOFT: begin
                if (!lock_s) begin
                    state_d = ST_HOLD;
                    io_d    = 1'b0;
                    core_d  = 1'b0;
                    rdy_d   = 1'b0;
                    cause_d = CAUSE_LOCK;
                end else if (state_q != ST_IO_REL && Soft_Reset_Req) begin
                    // Entering SOFT, or extending it from the request cycle.
                    state_d = ST_SOFT;
                    core_d  = 1'b0;
                    rdy_d   = 1'b0;
                    cnt_d   = SL_LD;
                    cause_d = CAUSE_SOFT;
                end else if (state_q != ST_RUN) begin
                    if (cnt_q == '0) begin
                        state_d = ST_RUN;
                        core_d  = 1'b1;
                        rdy_d   = 1'b1;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_HOLD;
                io_d    = 1'b0;
                core_d  = 1'b0;
                rdy_d   = 1'b0;
            end
        endcase
    end

    assign IO_Reset_N   = io_q;
    assign Core_Reset_N = core_q;
    assign Ready        = rdy_q;
    assign Reset_Cause  = cause_q;

endmodule

// File: tb/tb_sys_reset_ctrl.sv
// Directed bench for sys_reset_ctrl with small timing parameters and hand-computed cycle counts.
module tb_sys_reset_ctrl;

    logic       Clock = 1'b0;
    logic       Reset_N;
    logic       Locked;
    logic       Soft_Reset_Req;
    logic       IO_Reset_N;
    logic       Core_Reset_N;
    logic       Ready;
    logic [1:0] Reset_Cause;

    int total = 0;
    int bad   = 0;

    sys_reset_ctrl #(
        .SYNC_STAGES (2),
        .LOCK_FILTER (8),
        .STAGGER     (4),
        .SOFT_LEN    (3)
    ) dut (
        .Clock          (Clock),
        .Reset_N        (Reset_N),
        .Locked         (Locked),
        .Soft_Reset_Req (Soft_Reset_Req),
        .IO_Reset_N     (IO_Reset_N),
        .Core_Reset_N   (Core_Reset_N),
        .Ready          (Ready),
        .Reset_Cause    (Reset_Cause)
    );

    always #5 Clock = ~Clock;

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge Clock);
            #1;
        end
    endtask

    // Packs {IO, Core, Ready, Cause} so each check covers every output.
    task automatic chk(input string tag, input logic [4:0] exp);
        logic [4:0] obs;
        obs = {IO_Reset_N, Core_Reset_N, Ready, Reset_Cause};
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed io/core/rdy/cause=%b required=%b", tag, obs, exp);
        end
    endtask

    initial begin
        Reset_N        = 1'b0;
        Locked         = 1'b1;
        Soft_Reset_Req = 1'b0;

        // 1: power-on, Locked steady; IO at 11 edges after release, core 4 later
        step(5);
        chk("reset_state", 5'b000_00);
        Reset_N = 1'b1;
        step(10);
        chk("t1_io_before", 5'b000_00);
        step(1);
        chk("t1_io_rise", 5'b100_00);
        step(3);
        chk("t1_core_before", 5'b100_00);
        step(1);
        chk("t1_core_rise", 5'b111_00);

        // 2: glitch while filter count is 3 restarts the filter
        Reset_N = 1'b0;
        #2;
        chk("t2_async_reset", 5'b000_00);
        step(1);
        Reset_N = 1'b1;
        step(5);
        Locked = 1'b0;
        step(1);
        Locked = 1'b1;
        step(5);
        chk("t2_no_early_io", 5'b000_00);
        step(5);
        chk("t2_io_before", 5'b000_00);
        step(1);
        chk("t2_io_rise", 5'b100_00);
        step(4);
        chk("t2_run", 5'b111_00);

        // 3: single soft request -> core low exactly 3 cycles
        step(2);
        Soft_Reset_Req = 1'b1;
        step(1);
        Soft_Reset_Req = 1'b0;
        chk("t3_soft_c1", 5'b100_10);
        step(1);
        chk("t3_soft_c2", 5'b100_10);
        step(1);
        chk("t3_soft_c3", 5'b100_10);
        step(1);
        chk("t3_soft_done", 5'b111_10);

        // 4: second request when cnt=1 extends to 5 cycles total
        step(2);
        Soft_Reset_Req = 1'b1;
        step(1);
        Soft_Reset_Req = 1'b0;
        chk("t4_c1", 5'b100_10);
        step(1);
        Soft_Reset_Req = 1'b1;
        step(1);
        Soft_Reset_Req = 1'b0;
        chk("t4_c3", 5'b100_10);
        step(1);
        chk("t4_c4", 5'b100_10);
        step(1);
        chk("t4_c5", 5'b100_10);
        step(1);
        chk("t4_done", 5'b111_10);

        // 5: lock loss plus same-cycle soft request -> HOLD, cause lock
        step(2);
        Locked = 1'b0;
        step(1);
        chk("t5_loss_e1", 5'b111_10);
        step(1);
        Soft_Reset_Req = 1'b1;
        chk("t5_loss_e2", 5'b111_10);
        step(1);
        Soft_Reset_Req = 1'b0;
        chk("t5_loss_e3", 5'b000_01);
        step(3);
        chk("t5_hold", 5'b000_01);
        Locked = 1'b1;
        step(10);
        chk("t5_relock_io_before", 5'b000_01);
        step(1);
        chk("t5_relock_io", 5'b100_01);
        step(4);
        chk("t5_relock_run", 5'b111_01);

        // 6: async reset in IO_REL clears everything without a clock edge
        Locked = 1'b0;
        step(3);
        chk("t6_loss", 5'b000_01);
        Locked = 1'b1;
        step(11);
        chk("t6_io_rel", 5'b100_01);
        step(1);
        #2;
        Reset_N = 1'b0;
        #1;
        chk("t6_async", 5'b000_00);
        step(2);
        chk("t6_held", 5'b000_00);
        Reset_N = 1'b1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
